sram_audio_arbiter: RTL and testbench

- Shares the single 16-bit asynchronous SRAM between two requesters: the audio recorder (write channel) and the audio player (read channel).
- Sits between those engines and the SRAM pins and owns all SRAM control strobes.
- Sequences each access as a fixed-length, multi-cycle SRAM cycle with req/ack handshakes.
- Runs in the 12 MHz audio clock domain.

---
 rtl/sram_audio_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_audio_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_audio_arbiter.sv
// Shares one 16-bit asynchronous SRAM between the audio recorder (write) and player (read).
// Optional round-robin arbitration when SRAM_ARB_RR_EN is defined; fixed write>read otherwise.
module sram_audio_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [1:0]        i_wr_be,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_UB_N,
  output logic              o_SRAM_LB_N
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StHold} state_t;

  localparam logic [3:0] LastCnt = 4'(ACCESS_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq_out;
  logic              r_dq_oe;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_ub_n;
  logic              r_lb_n;
  logic              r_wr_ack;
  logic              r_rd_ack;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_busy;

  logic              w_grant_wr;
  logic              w_grant_rd;

`ifdef SRAM_ARB_RR_EN
  // 1 = last grant went to the write channel; reset value favours write on the first tie.
  logic r_last_wr;

  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (i_wr_req && i_rd_req) begin
      w_grant_wr = ~r_last_wr;
      w_grant_rd = r_last_wr;
    end else begin
      w_grant_wr = i_wr_req;
      w_grant_rd = i_rd_req;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_wr <= 1'b0;
    end else if (r_state == StIdle && (w_grant_wr || w_grant_rd)) begin
      r_last_wr <= w_grant_wr;
    end
  end
`else
  always_comb begin
    w_grant_wr = i_wr_req;
    w_grant_rd = i_rd_req & ~i_wr_req;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_dq_out  <= '0;
      r_dq_oe   <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_ub_n    <= 1'b1;
      r_lb_n    <= 1'b1;
      r_wr_ack  <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_wr_ack <= 1'b0;
      r_rd_ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_grant_wr) begin
            r_state  <= StWrite;
            r_cnt    <= 4'd0;
            r_addr   <= i_wr_addr;
            r_dq_out <= i_wr_data;
            r_dq_oe  <= 1'b1;
            r_ce_n   <= 1'b0;
            r_we_n   <= 1'b0;
            r_oe_n   <= 1'b1;
            r_ub_n   <= ~i_wr_be[1];
            r_lb_n   <= ~i_wr_be[0];
            r_busy   <= 1'b1;
          end else if (w_grant_rd) begin
            r_state <= StRead;
            r_cnt   <= 4'd0;
            r_addr  <= i_rd_addr;
            r_dq_oe <= 1'b0;
            r_ce_n  <= 1'b0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b0;
            r_ub_n  <= 1'b0;
            r_lb_n  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        StWrite: begin
          if (r_cnt == LastCnt) begin
            // Data stays driven through HOLD for the SRAM data-hold time.
            r_state  <= StHold;
            r_we_n   <= 1'b1;
            r_wr_ack <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StRead: begin
          if (r_cnt == LastCnt) begin
            r_state   <= StHold;
            r_oe_n    <= 1'b1;
            r_rd_ack  <= 1'b1;
            r_rd_data <= io_SRAM_DQ;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StHold: begin
          r_state <= StIdle;
          r_ce_n  <= 1'b1;
          r_ub_n  <= 1'b1;
          r_lb_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_SRAM_DQ  = r_dq_oe ? r_dq_out : {DATA_W{1'bz}};
  assign o_SRAM_ADDR = r_addr;
  assign o_SRAM_CE_N = r_ce_n;
  assign o_SRAM_OE_N = r_oe_n;
  assign o_SRAM_WE_N = r_we_n;
  assign o_SRAM_UB_N = r_ub_n;
  assign o_SRAM_LB_N = r_lb_n;
  assign o_wr_ack    = r_wr_ack;
  assign o_rd_ack    = r_rd_ack;
  assign o_rd_data   = r_rd_data;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_sram_audio_arbiter.sv
// Directed bench for sram_audio_arbiter: main DUT at ACCESS_CYCLES=2 with an SRAM model,
// plus two timing-only instances at ACCESS_CYCLES=1 and 15.
module tb_sram_audio_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance, ACCESS_CYCLES = 2
  logic        wr_req, rd_req, wr_ack, rd_ack, busy;
  logic [19:0] wr_addr, rd_addr, s_addr;
  logic [15:0] wr_data, rd_data;
  logic [1:0]  wr_be;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;
  wire  [15:0] sram_dq;

  sram_audio_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
    .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_ack(rd_ack),
    .o_busy(busy), .o_SRAM_ADDR(s_addr), .io_SRAM_DQ(sram_dq),
    .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_WE_N(we_n),
    .o_SRAM_UB_N(ub_n), .o_SRAM_LB_N(lb_n)
  );

  // SRAM model (1K words) and a bench-side bus driver used only while checking DQ release
  logic [15:0] mem [0:1023];
  bit          mem_loaded = 1'b0;
  logic        tb_dq_en;
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[s_addr[9:0]] : 16'hzzzz;
  assign sram_dq = tb_dq_en ? 16'h5A5A : 16'hzzzz;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
      mem[256]   <= 16'h1234;
      mem_loaded <= 1'b1;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[s_addr[9:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[s_addr[9:0]][15:8] <= sram_dq[15:8];
    end
  end

  // Timing-only instances
  logic        a1_wr_req, a1_wr_ack, a1_rd_ack, a1_busy;
  logic [15:0] a1_rd_data;
  logic [19:0] a1_addr;
  logic        a1_ce_n, a1_oe_n, a1_we_n, a1_ub_n, a1_lb_n;
  wire  [15:0] a1_dq;

  sram_audio_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(1)) u_dut_a1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(a1_wr_req), .i_wr_addr(20'h00055), .i_wr_data(16'h1111), .i_wr_be(2'b11),
    .o_wr_ack(a1_wr_ack),
    .i_rd_req(1'b0), .i_rd_addr(20'h0), .o_rd_data(a1_rd_data), .o_rd_ack(a1_rd_ack),
    .o_busy(a1_busy), .o_SRAM_ADDR(a1_addr), .io_SRAM_DQ(a1_dq),
    .o_SRAM_CE_N(a1_ce_n), .o_SRAM_OE_N(a1_oe_n), .o_SRAM_WE_N(a1_we_n),
    .o_SRAM_UB_N(a1_ub_n), .o_SRAM_LB_N(a1_lb_n)
  );

  logic        a15_rd_req, a15_wr_ack, a15_rd_ack, a15_busy;
  logic [15:0] a15_rd_data;
  logic [19:0] a15_addr;
  logic        a15_ce_n, a15_oe_n, a15_we_n, a15_ub_n, a15_lb_n;
  wire  [15:0] a15_dq;

  sram_audio_arbiter #(.ADDR_W(20), .DATA_W(16), .ACCESS_CYCLES(15)) u_dut_a15 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(1'b0), .i_wr_addr(20'h0), .i_wr_data(16'h0), .i_wr_be(2'b00),
    .o_wr_ack(a15_wr_ack),
    .i_rd_req(a15_rd_req), .i_rd_addr(20'h00077), .o_rd_data(a15_rd_data),
    .o_rd_ack(a15_rd_ack),
    .o_busy(a15_busy), .o_SRAM_ADDR(a15_addr), .io_SRAM_DQ(a15_dq),
    .o_SRAM_CE_N(a15_ce_n), .o_SRAM_OE_N(a15_oe_n), .o_SRAM_WE_N(a15_we_n),
    .o_SRAM_UB_N(a15_ub_n), .o_SRAM_LB_N(a15_lb_n)
  );

  // Sticky flag: WE_N and OE_N low together on any instance
  bit both_low = 1'b0;
  always @(negedge clk) begin
    if ((!we_n && !oe_n) || (!a1_we_n && !a1_oe_n) || (!a15_we_n && !a15_oe_n))
      both_low = 1'b1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write on the main instance; lat counts cycles from the grant edge to the ack cycle.
  task automatic wr_txn(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be,
                        output int lat, output int we_low, output bit bad,
                        output logic [15:0] hold_dq);
    @(negedge clk);
    wr_addr = a; wr_data = d; wr_be = be; wr_req = 1'b1;
    lat = 0; we_low = 0; bad = 1'b0; hold_dq = 16'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!we_n) begin
        we_low++;
        if (s_addr !== a || sram_dq !== d || ub_n !== ~be[1] || lb_n !== ~be[0] ||
            oe_n !== 1'b1 || ce_n !== 1'b0) bad = 1'b1;
      end
      if (wr_ack) begin
        lat = k;
        hold_dq = sram_dq;
        break;
      end
    end
    wr_req = 1'b0;
  endtask

  task automatic rd_txn(input logic [19:0] a, output int lat, output int oe_low,
                        output bit bad, output logic [15:0] data);
    @(negedge clk);
    rd_addr = a; rd_req = 1'b1;
    lat = 0; oe_low = 0; bad = 1'b0; data = 16'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!oe_n) begin
        oe_low++;
        if (we_n !== 1'b1 || s_addr !== a || ce_n !== 1'b0 || ub_n !== 1'b0 || lb_n !== 1'b0)
          bad = 1'b1;
      end
      if (rd_ack) begin
        lat = k;
        data = rd_data;
        break;
      end
    end
    rd_req = 1'b0;
  endtask

  initial begin
    int          lat, cnt, wk, rk, rs;
    bit          bad, ack_seen;
    logic [15:0] dq, rdv;

    rst_n = 1'b0; tb_dq_en = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    a1_wr_req = 1'b0; a15_rd_req = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    check("rst_acks", {wr_ack, rd_ack, busy}, 3'b000);
    check("rst_addr", s_addr, 20'h0);
    check("rst_rd_data", rd_data, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    check("idle_dq_released", sram_dq, 16'h5A5A);
    tb_dq_en = 1'b0;

    // Single full write
    wr_txn(20'h00010, 16'hA5C3, 2'b11, lat, cnt, bad, dq);
    check("wr_ack_latency", lat, 3);
    check("wr_we_low_cycles", cnt, 2);
    check("wr_bus_during_we", bad, 1'b0);
    check("wr_hold_dq", dq, 16'hA5C3);
    @(negedge clk);
    check("wr_ack_one_pulse", {wr_ack, busy, ce_n}, 3'b001);
    check("wr_mem_0x10", mem[16], 16'hA5C3);

    // Byte write then read back
    wr_txn(20'h00020, 16'hA5C3, 2'b01, lat, cnt, bad, dq);
    check("bw_ack_latency", lat, 3);
    check("bw_lanes_during_we", bad, 1'b0);
    rd_txn(20'h00020, lat, cnt, bad, rdv);
    check("bw_readback", rdv, 16'h00C3);

    // Preloaded read
    rd_txn(20'h00100, lat, cnt, bad, rdv);
    check("rd_ack_latency", lat, 3);
    check("rd_oe_low_cycles", cnt, 2);
    check("rd_bus_during_oe", bad, 1'b0);
    check("rd_data", rdv, 16'h1234);

    // Contention: write first, read starts after HOLD + IDLE
    @(negedge clk);
    wr_addr = 20'h00030; wr_data = 16'hBEEF; wr_be = 2'b11; wr_req = 1'b1;
    rd_addr = 20'h00100; rd_req = 1'b1;
    wk = 0; rk = 0; rs = 0; rdv = 16'h0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (!oe_n && rs == 0) rs = k;
      if (wr_ack && wk == 0) begin wk = k; wr_req = 1'b0; end
      if (rd_ack && rk == 0) begin rk = k; rdv = rd_data; rd_req = 1'b0; end
      if (wk != 0 && rk != 0) break;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    check("cont_wr_ack_cycle", wk, 3);
    check("cont_rd_start_cycle", rs, 5);
    check("cont_rd_ack_cycle", rk, 7);
    check("cont_rd_data", rdv, 16'h1234);
    check("cont_wr_mem", mem[48], 16'hBEEF);

    // Reset asserted mid-write: strobes release asynchronously, no ack afterwards
    @(negedge clk);
    wr_addr = 20'h00040; wr_data = 16'h7777; wr_be = 2'b11; wr_req = 1'b1;
    @(negedge clk);
    check("rstmid_in_write", {ce_n, we_n}, 2'b00);
    #2 rst_n = 1'b0; wr_req = 1'b0;
    #1;
    check("rstmid_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    check("rstmid_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wr_ack || rd_ack) ack_seen = 1'b1;
    end
    check("rstmid_no_ack", ack_seen, 1'b0);

    // ACCESS_CYCLES = 1 write
    @(negedge clk);
    a1_wr_req = 1'b1; lat = 0; cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!a1_we_n) cnt++;
      if (a1_wr_ack) begin lat = k; break; end
    end
    a1_wr_req = 1'b0;
    check("ac1_wr_ack_latency", lat, 2);
    check("ac1_we_low_cycles", cnt, 1);

    // ACCESS_CYCLES = 15 read
    @(negedge clk);
    a15_rd_req = 1'b1; lat = 0; cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!a15_oe_n) cnt++;
      if (a15_rd_ack) begin lat = k; break; end
    end
    a15_rd_req = 1'b0;
    check("ac15_rd_ack_latency", lat, 16);
    check("ac15_oe_low_cycles", cnt, 15);

    repeat (2) @(negedge clk);
    check("never_we_oe_both_low", both_low, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
